// File: rtl/demux4_rr_dispatcher.sv
// Round-robin 1:4 dispatcher: holds one word and offers it to the next enabled
// channel after the previous target, releasing it when that channel is ready.
module demux4_rr_dispatcher #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    en_mask,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [CW-1:0] dlv_cnt
);

  // state | meaning
  // IDLE  | no word held; accepting when any channel is enabled
  // SEND  | word held in out_data, offered to channel sel until accepted
  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] tgt;
  logic       accept;
  logic       deliver;

  assign in_ready = (state == IDLE) && (en_mask != 4'b0000);
  assign accept   = in_valid && in_ready;
  assign deliver  = (state == SEND) && out_ready[sel];

  // Scan from the far end back to ptr so the closest enabled channel wins.
  always_comb begin
    tgt = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (en_mask[ptr + 2'(k)]) tgt = ptr + 2'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_data  <= '0;
      out_valid <= 4'b0000;
      busy      <= 1'b0;
      dlv_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_data  <= in_data;
            sel       <= tgt;
            out_valid <= 4'b0001 << tgt;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (deliver) begin
            ptr       <= sel + 2'd1;
            dlv_cnt   <= dlv_cnt + CW'(1);
            out_valid <= 4'b0000;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Bench for demux4_rr_dispatcher: directed scenarios plus random traffic
// compared against a word-level round-robin reference model.
module tb_demux4_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] en_mask;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] sel;
  logic       busy;
  logic [15:0] dlv_cnt;

  int n_pass = 0;
  int n_total = 0;

  // reference model: whether a word is held, where it goes, and the rotation point
  bit       m_send;
  int       m_sel;
  int       m_ptr;
  int       m_cnt;
  bit [7:0] m_data;
  bit       m_acc;
  bit       m_dlv;

  demux4_rr_dispatcher #(.DW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en_mask(en_mask), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .sel(sel), .busy(busy),
    .dlv_cnt(dlv_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_send = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_data = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model, return 1 time unit after the edge.
  task automatic tick(input bit iv, input bit [7:0] d, input bit [3:0] m, input bit [3:0] r);
    bit found;
    @(negedge clk);
    in_valid = iv; in_data = d; en_mask = m; out_ready = r;
    m_acc = 0; m_dlv = 0; found = 0;
    if (!m_send && iv && m != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && m[(m_ptr + k) % 4]) begin
          m_sel = (m_ptr + k) % 4;
          found = 1;
        end
      end
      m_data = d; m_send = 1; m_acc = 1;
    end else if (m_send && r[m_sel]) begin
      m_ptr = (m_sel + 1) % 4;
      m_cnt = (m_cnt + 1) % 65536;
      m_send = 0; m_dlv = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = 0; en_mask = 4'b1111; out_ready = 4'b0000;
    model_reset();
    #3;
    n_total++; if (out_valid !== 4'b0000) $display("FAIL reset out_valid got %b exp 0000", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
    n_total++; if (sel !== 2'd0) $display("FAIL reset sel got %0d exp 0", sel); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset out_data got %h exp 00", out_data); else n_pass++;
    n_total++; if (dlv_cnt !== 16'd0) $display("FAIL reset dlv_cnt got %0d exp 0", dlv_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready(mask=1111) got %b exp 1", in_ready); else n_pass++;
    en_mask = 4'b0000; #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset in_ready(mask=0) got %b exp 0", in_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_rr_all();
    bit [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      tick(1, words[i], 4'b1111, 4'b1111);
      n_total++; if (out_valid !== (4'b0001 << (i % 4))) $display("FAIL rr_all out_valid word %0d got %b exp ch %0d", i, out_valid, i % 4); else n_pass++;
      n_total++; if (sel !== 2'(i % 4)) $display("FAIL rr_all sel word %0d got %0d exp %0d", i, sel, i % 4); else n_pass++;
      n_total++; if (out_data !== words[i] || busy !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL rr_all hold word %0d got data %h busy %b in_ready %b exp %h 1 0", i, out_data, busy, in_ready, words[i]); else n_pass++;
      tick(1, 8'hEE, 4'b1111, 4'b1111);
      n_total++; if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL rr_all release word %0d got ov %b busy %b in_ready %b exp 0000 0 1", i, out_valid, busy, in_ready); else n_pass++;
    end
    n_total++; if (dlv_cnt !== 16'd5) $display("FAIL rr_all dlv_cnt got %0d exp 5", dlv_cnt); else n_pass++;
  endtask

  task automatic test_masked();
    int exp_ch [4] = '{1, 3, 1, 3};
    for (int i = 0; i < 4; i++) begin
      tick(1, 8'(8'h60 + i), 4'b1010, 4'b1111);
      n_total++; if (out_valid !== (4'b0001 << exp_ch[i]) || sel !== 2'(exp_ch[i]))
        $display("FAIL masked target word %0d got ov %b sel %0d exp ch %0d", i, out_valid, sel, exp_ch[i]); else n_pass++;
      tick(0, 8'h00, 4'b1010, 4'b1111);
      n_total++; if ((out_valid & 4'b0101) !== 4'b0000 || busy !== 1'b0)
        $display("FAIL masked release word %0d got ov %b busy %b exp 0000 0", i, out_valid, busy); else n_pass++;
    end
    n_total++; if (dlv_cnt !== 16'd9) $display("FAIL masked dlv_cnt got %0d exp 9", dlv_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    tick(1, 8'hA5, 4'b1111, 4'b1110);
    for (int c = 0; c < 5; c++) begin
      n_total++; if (out_valid !== 4'b0001 || out_data !== 8'hA5 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL stall cycle %0d got ov %b data %h in_ready %b busy %b exp 0001 a5 0 1", c, out_valid, out_data, in_ready, busy); else n_pass++;
      tick(1, 8'h5A, 4'b1111, 4'b1110);
    end
    n_total++; if (dlv_cnt !== 16'd9 || out_valid !== 4'b0001) $display("FAIL stall held got cnt %0d ov %b exp 9 0001", dlv_cnt, out_valid); else n_pass++;
    tick(0, 8'h00, 4'b1111, 4'b0001);
    n_total++; if (dlv_cnt !== 16'd10 || out_valid !== 4'b0000 || busy !== 1'b0)
      $display("FAIL stall delivery got cnt %0d ov %b busy %b exp 10 0000 0", dlv_cnt, out_valid, busy); else n_pass++;
  endtask

  task automatic test_zero_mask();
    for (int c = 0; c < 4; c++) begin
      tick(1, 8'hC3, 4'b0000, 4'b1111);
      n_total++; if (in_ready !== 1'b0 || out_valid !== 4'b0000 || dlv_cnt !== 16'd10)
        $display("FAIL zero_mask cycle %0d got in_ready %b ov %b cnt %0d exp 0 0000 10", c, in_ready, out_valid, dlv_cnt); else n_pass++;
    end
    tick(1, 8'hC4, 4'b0100, 4'b0000);
    n_total++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hC4)
      $display("FAIL zero_mask then 0100 got ov %b sel %0d data %h exp 0100 2 c4", out_valid, sel, out_data); else n_pass++;
    tick(0, 8'h00, 4'b0100, 4'b0100);
  endtask

  task automatic test_mask_change();
    tick(1, 8'h77, 4'b0100, 4'b0000);
    n_total++; if (sel !== 2'd2 || out_valid !== 4'b0100) $display("FAIL mask_change accept got sel %0d ov %b exp 2 0100", sel, out_valid); else n_pass++;
    tick(0, 8'h00, 4'b1011, 4'b1011);
    n_total++; if (out_valid !== 4'b0100 || busy !== 1'b1) $display("FAIL mask_change retarget got ov %b busy %b exp 0100 1", out_valid, busy); else n_pass++;
    tick(0, 8'h00, 4'b1011, 4'b0100);
    n_total++; if (busy !== 1'b0 || dlv_cnt !== 16'd12) $display("FAIL mask_change delivery got busy %b cnt %0d exp 0 12", busy, dlv_cnt); else n_pass++;
    tick(1, 8'h78, 4'b1011, 4'b0000);
    n_total++; if (sel !== 2'd3 || out_valid !== 4'b1000) $display("FAIL mask_change next got sel %0d ov %b exp 3 1000", sel, out_valid); else n_pass++;
    tick(0, 8'h00, 4'b1011, 4'b1000);
  endtask

  task automatic test_random();
    bit [3:0] m;
    bit [3:0] exp_ov;
    for (int c = 0; c < 400; c++) begin
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) m = 4'b0000;
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), m, 4'($urandom));
      exp_ov = m_send ? (4'b0001 << m_sel) : 4'b0000;
      n_total++;
      if (out_valid !== exp_ov || busy !== m_send || sel !== 2'(m_sel) || out_data !== m_data ||
          dlv_cnt !== 16'(m_cnt) || in_ready !== (!m_send && m != 4'b0000))
        $display("FAIL random cycle %0d got ov %b busy %b sel %0d data %h cnt %0d rdy %b exp %b %b %0d %h %0d %b",
                 c, out_valid, busy, sel, out_data, dlv_cnt, in_ready,
                 exp_ov, m_send, m_sel, m_data, m_cnt, (!m_send && m != 4'b0000));
      else n_pass++;
    end
    while (m_send) tick(0, 8'h00, 4'b1111, 4'b1111);
  endtask

  task automatic test_reset_mid_send();
    tick(1, 8'h99, 4'b1111, 4'b0000);
    tick(0, 8'h00, 4'b1111, 4'b0000);
    n_total++; if (busy !== 1'b1) $display("FAIL mid_reset pre busy got %b exp 1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (out_valid !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || dlv_cnt !== 16'd0)
      $display("FAIL mid_reset got ov %b busy %b sel %0d cnt %0d exp 0000 0 0 0", out_valid, busy, sel, dlv_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    tick(1, 8'h3C, 4'b1111, 4'b0000);
    n_total++; if (sel !== 2'd0 || out_valid !== 4'b0001 || out_data !== 8'h3C)
      $display("FAIL mid_reset first word got sel %0d ov %b data %h exp 0 0001 3c", sel, out_valid, out_data); else n_pass++;
    tick(0, 8'h00, 4'b1111, 4'b0001);
    n_total++; if (dlv_cnt !== 16'd1) $display("FAIL mid_reset count got %0d exp 1", dlv_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_masked();
    test_stall();
    test_zero_mask();
    test_mask_change();
    test_random();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
